hazard_fwd_unit: RTL and testbench

- Parametrised hazard-detection and forwarding unit for the DLX integer pipeline; it sits beside the ID stage.
- Tracks destinations of the last DEPTH in-flight instructions in a registered scoreboard shift pipeline.
- Produces per-operand forwarding selects, a load-use stall and a saturating stall-cycle counter.
- Generalises the fixed two-stage rW/load tracking of the current control decoder to any depth and any load latency.

---
 rtl/hazard_fwd_unit.sv | 78 +++++++
 tb/tb_hazard_fwd_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard-based load-use stall and operand forwarding for the ID stage
module hazard_fwd_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [DEPTH:1]    v_q, v_d, wr_q, wr_d, ld_q, ld_d;
  logic [REG_AW-1:0] rd_q [1:DEPTH];
  logic [REG_AW-1:0] rd_d [1:DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [SEL_W-1:0]  ka, kb;
  logic              la, lb, ok_a, ok_b, haz_a, haz_b;
  always_comb begin
    ka = '0;
    kb = '0;
    la = 1'b0;
    lb = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v_q[k] && wr_q[k] && rd_q[k] == id_rs1) begin
        ka = SEL_W'(k);
        la = ld_q[k];
      end
      if (v_q[k] && wr_q[k] && rd_q[k] == id_rs2) begin
        kb = SEL_W'(k);
        lb = ld_q[k];
      end
    end
    ok_a  = id_valid && id_rs1_used && id_rs1 != '0 && ka != '0;
    ok_b  = id_valid && id_rs2_used && id_rs2 != '0 && kb != '0;
    haz_a = ok_a && la && ka <= SEL_W'(LOAD_LAT);
    haz_b = ok_b && lb && kb <= SEL_W'(LOAD_LAT);
    stall = (haz_a || haz_b) && !flush;
    fwd_a = (ok_a && !stall && !flush) ? ka : '0;
    fwd_b = (ok_b && !stall && !flush) ? kb : '0;
  end
  always_comb begin
    v_d      = {v_q[DEPTH-1:1], id_valid && !stall && !flush};
    wr_d     = {wr_q[DEPTH-1:1], id_reg_wr};
    ld_d     = {ld_q[DEPTH-1:1], id_is_load};
    rd_d[1]  = id_rd;
    for (int k = 2; k <= DEPTH; k++) rd_d[k] = rd_q[k-1];
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: two parameterisations checked against a queue-based reference model
module tb_hazard_fwd_unit;
  typedef struct packed {bit v; bit [4:0] rd; bit wr; bit ld;} ent_t;
  logic clk = 0, reset = 1;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_wr = 0, id_is_load = 0, flush = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic st0, st1;
  logic [1:0] fa0, fb0;
  logic [2:0] fa1, fb1;
  logic [3:0] cnt0;
  logic [15:0] cnt1;
  int total = 0, bad = 0;
  ent_t q0[$], q1[$];
  int c0 = 0, c1 = 0;
  bit ms0, ms1;
  int ma0, mb0, ma1, mb1;
  always #5 clk = ~clk;
  hazard_fwd_unit #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .SEL_W(2), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(st0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0));
  hazard_fwd_unit #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2), .SEL_W(3), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(st1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1));
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int young(input ent_t q[$], input bit [4:0] rs, input bit used);
    if (!used || rs == 0 || !id_valid) return 0;
    foreach (q[i]) if (q[i].v && q[i].wr && q[i].rd == rs) return i + 1;
    return 0;
  endfunction
  task automatic mdl(input ent_t q[$], input int lat, output bit st, output int fa, output int fb);
    int ka, kb;
    bit ha, hb;
    ka = young(q, id_rs1, id_rs1_used);
    kb = young(q, id_rs2, id_rs2_used);
    ha = ka != 0 && q[ka-1].ld && ka <= lat;
    hb = kb != 0 && q[kb-1].ld && kb <= lat;
    st = (ha || hb) && !flush;
    fa = (st || flush) ? 0 : ka;
    fb = (st || flush) ? 0 : kb;
  endtask
  task automatic check_all();
    mdl(q0, 1, ms0, ma0, mb0);
    mdl(q1, 2, ms1, ma1, mb1);
    chk("d0_stall", st0, ms0);
    chk("d0_fwd_a", fa0, ma0);
    chk("d0_fwd_b", fb0, mb0);
    chk("d0_cnt", cnt0, c0);
    chk("d1_stall", st1, ms1);
    chk("d1_fwd_a", fa1, ma1);
    chk("d1_fwd_b", fb1, mb1);
    chk("d1_cnt", cnt1, c1);
  endtask
  task automatic adv();
    ent_t e;
    e = '{v: id_valid, rd: id_rd, wr: id_reg_wr, ld: id_is_load};
    @(posedge clk);
    q0.push_front((ms0 || flush) ? ent_t'(0) : e);
    void'(q0.pop_back());
    q1.push_front((ms1 || flush) ? ent_t'(0) : e);
    void'(q1.pop_back());
    if (ms0 && c0 < 15) c0++;
    if (ms1 && c1 < 65535) c1++;
    #1;
  endtask
  task automatic drive(input bit v, input bit [4:0] a, input bit [4:0] b, input bit ua, input bit ub,
                       input bit [4:0] d, input bit w, input bit l, input bit f);
    id_valid = v; id_rs1 = a; id_rs2 = b; id_rs1_used = ua; id_rs2_used = ub;
    id_rd = d; id_reg_wr = w; id_is_load = l; flush = f;
  endtask
  task automatic cyc(input bit v, input bit [4:0] a, input bit [4:0] b, input bit ua, input bit ub,
                     input bit [4:0] d, input bit w, input bit l, input bit f);
    drive(v, a, b, ua, ub, d, w, l, f);
    @(negedge clk);
    check_all();
    adv();
  endtask
  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic clear_models();
    q0 = {}; q1 = {};
    repeat (3) q0.push_back(ent_t'(0));
    repeat (4) q1.push_back(ent_t'(0));
    c0 = 0; c1 = 0;
  endtask
  initial begin
    clear_models();
    drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
    #12;
    check_all();
    reset = 0;
    @(posedge clk); #1;
    cyc(1, 1, 2, 1, 1, 3, 1, 0, 0);
    drive(1, 3, 5, 1, 1, 4, 1, 0, 0);
    @(negedge clk);
    chk("b2b_fwd_a", fa0, 1);
    chk("b2b_fwd_b", fb0, 0);
    check_all();
    adv();
    repeat (3) nop();
    for (int gap = 1; gap <= 4; gap++) begin
      cyc(1, 1, 2, 1, 1, 3, 1, 0, 0);
      repeat (gap - 1) nop();
      drive(1, 7, 3, 1, 1, 6, 1, 0, 0);
      @(negedge clk);
      chk("gap_fwd_b", fb0, gap == 4 ? 0 : gap);
      check_all();
      adv();
      repeat (4) nop();
    end
    cyc(1, 1, 0, 1, 0, 8, 1, 1, 0);
    repeat (4) cyc(1, 8, 8, 1, 1, 9, 1, 0, 0);
    repeat (4) nop();
    cyc(1, 1, 2, 1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 4, 1, 0, 0);
    cyc(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 1, 2, 1, 1, 5, 1, 0, 0);
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0);
    @(negedge clk);
    chk("shadow_fwd", fa0, 1);
    check_all();
    adv();
    repeat (4) nop();
    cyc(1, 1, 0, 1, 0, 8, 1, 1, 0);
    cyc(1, 8, 1, 1, 1, 9, 1, 0, 1);
    repeat (4) nop();
    cyc(1, 1, 0, 1, 0, 8, 1, 1, 0);
    drive(1, 8, 1, 1, 1, 9, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst_stall", st1, 1);
    check_all();
    reset = 1;
    #1;
    chk("rst_stall", st1, 0);
    chk("rst_cnt0", cnt0, 0);
    clear_models();
    check_all();
    #1 reset = 0;
    adv();
    repeat (4) nop();
    repeat (25) begin
      cyc(1, 1, 0, 1, 0, 8, 1, 1, 0);
      cyc(1, 8, 8, 1, 1, 9, 1, 0, 0);
      repeat (3) nop();
    end
    chk("sat_cnt", cnt0, 15);
    repeat (400) cyc($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                     $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
